// File: rtl/timer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_pkg: bus codes, range limits, modes and FSM states for timer_programmer
// Revision 1.0
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam logic [1:0] A_CTRL = 2'b10;
    localparam logic [1:0] A_IDLE = 2'b11;

    localparam logic [7:0] C0_MIN = 8'd2;
    localparam logic [7:0] C0_MAX = 8'd150;
    localparam logic [7:0] C1_MIN = 8'd50;
    localparam logic [7:0] C1_MAX = 8'd200;

    typedef enum logic [2:0] {
        MODE0 = 3'd0,
        MODE1 = 3'd1,
        MODE2 = 3'd2,
        MODE3 = 3'd3,
        MODE4 = 3'd4
    } mode_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_MODE   = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;
    localparam logic [1:0] ERR_PARITY = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CTRL = 3'd1,
        MSN  = 3'd2,
        LSN  = 3'd3,
        GAP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/timer_req_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_req_check: combinational legality check of a counter-programming request
// Revision 1.0
// ---------------------------------------------------------------------------
module timer_req_check
    import timer_pkg::*;
(
    input  logic       sel,
    input  logic [2:0] mode,
    input  logic [7:0] count,
    output logic       ok,
    output logic [1:0] code
);

    logic [7:0] lo;
    logic [7:0] hi;

    // Mode beats range beats parity when several rules are broken at once.
    always_comb begin
        lo   = sel ? C1_MIN : C0_MIN;
        hi   = sel ? C1_MAX : C0_MAX;
        code = ERR_NONE;
        if (mode > MODE4) begin
            code = ERR_MODE;
        end else if (count < lo || count > hi) begin
            code = ERR_RANGE;
        end else if ((mode == MODE2 && count[0]) ||
                     ((mode == MODE3 || mode == MODE4) && !count[0])) begin
            code = ERR_PARITY;
        end
        ok = (code == ERR_NONE);
    end

endmodule
`default_nettype wire

// File: rtl/timer_programmer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_programmer: serialises checked requests into the timer's 3-cycle write
// Revision 1.0
// ---------------------------------------------------------------------------
module timer_programmer
    import timer_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter bit CHECK_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_sel,
    input  logic [2:0] req_mode,
    input  logic [7:0] req_count,
    output logic [3:0] d,
    output logic [1:0] a,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] shadow0_count,
    output logic [2:0] shadow0_mode,
    output logic [7:0] shadow1_count,
    output logic [2:0] shadow1_mode
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t        state, state_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic          lat_sel;
    logic [2:0]    lat_mode;
    logic [7:0]    lat_count;
    logic [3:0]    d_nx;
    logic [1:0]    a_nx, code_nx;
    logic          done_nx, err_nx, load;
    logic          chk_ok, req_ok;
    logic [1:0]    chk_code;

    timer_req_check u_check (
        .sel   (req_sel),
        .mode  (req_mode),
        .count (req_count),
        .ok    (chk_ok),
        .code  (chk_code)
    );

    assign req_ok    = chk_ok || !CHECK_EN;
    assign req_ready = (state == IDLE) && rst_n;

    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        a_nx     = A_IDLE;
        d_nx     = 4'h0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        code_nx  = err_code;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_ok) begin
                        state_nx = CTRL;
                        a_nx     = A_CTRL;
                        d_nx     = {req_sel, req_mode};
                        load     = 1'b1;
                    end else begin
                        err_nx  = 1'b1;
                        code_nx = chk_code;
                    end
                end
            end
            CTRL: begin
                state_nx = MSN;
                a_nx     = {1'b0, lat_sel};
                d_nx     = lat_count[7:4];
            end
            MSN: begin
                state_nx = LSN;
                d_nx     = lat_count[3:0];
            end
            LSN: begin
                done_nx = 1'b1;
                if (GAP_CYCLES > 0) begin
                    state_nx = GAP;
                    gap_nx   = GW'(GAP_CYCLES - 1);
                end else begin
                    state_nx = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_cnt - GW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            a         <= A_IDLE;
            d         <= 4'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            lat_sel   <= 1'b0;
            lat_mode  <= 3'd0;
            lat_count <= 8'd0;
        end else begin
            state    <= state_nx;
            gap_cnt  <= gap_nx;
            a        <= a_nx;
            d        <= d_nx;
            done     <= done_nx;
            err      <= err_nx;
            err_code <= code_nx;
            if (load) begin
                lat_sel   <= req_sel;
                lat_mode  <= req_mode;
                lat_count <= req_count;
            end
        end
    end

    // Shadows commit on the edge that raises done, so an aborted sequence never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow0_count <= 8'd0;
            shadow0_mode  <= 3'd0;
            shadow1_count <= 8'd0;
            shadow1_mode  <= 3'd0;
        end else if (state == LSN) begin
            if (lat_sel) begin
                shadow1_count <= lat_count;
                shadow1_mode  <= lat_mode;
            end else begin
                shadow0_count <= lat_count;
                shadow0_mode  <= lat_mode;
            end
        end
    end

endmodule
`default_nettype wire
